// File: rtl/vend_pkg.sv
// Shared types and width constants for the vending transaction controller.
// TIMEOUT_CYCLES is only consumed when VEND_TIMEOUT_EN is defined.
package vend_pkg;

  localparam int ADDR_W         = 2;
  localparam int PRICE_W        = 4;
  localparam int COIN_W         = 4;
  localparam int CREDIT_W       = 5;
  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COLLECT,
    DISPENSE,
    REFUND
  } state_e;

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Bus between the transaction controller and its surroundings: user
// inputs, price ROM address/data and the registered result pulses.
// The controller uses the slave modport; the environment uses master.
interface vend_txn_ctrl_if;
  import vend_pkg::*;

  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic                coin_valid;
  logic [COIN_W-1:0]   coin_val;
  logic                cancel;
  logic [ADDR_W-1:0]   price_addr;
  logic [PRICE_W-1:0]  price_in;
  logic                dispense;
  logic [ADDR_W-1:0]   dispense_item;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                coin_reject;
  logic                sel_err;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output sel_valid, sel_addr, coin_valid, coin_val, cancel, price_in,
    input  price_addr, dispense, dispense_item, change_valid, change_amt,
           coin_reject, sel_err, credit, busy
  );

  modport slave (
    input  sel_valid, sel_addr, coin_valid, coin_val, cancel, price_in,
    output price_addr, dispense, dispense_item, change_valid, change_amt,
           coin_reject, sel_err, credit, busy
  );

endinterface

// File: rtl/vend_credit_acc.sv
// Credit accumulator: holds inserted credit, adds a coin on request,
// clears on request and flags whether credit-plus-coin covers the price.
module vend_credit_acc
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                add_i,
  input  logic                clr_i,
  input  logic [COIN_W-1:0]   coin_i,
  input  logic [PRICE_W-1:0]  price_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [CREDIT_W-1:0] sum_o,
  output logic                ge_o
);

  logic [CREDIT_W-1:0] credit_q;

  // Candidate credit if the presented coin is accepted; CREDIT_W covers max price + max coin.
  assign sum_o    = credit_q + CREDIT_W'(coin_i);
  assign ge_o     = (sum_o >= CREDIT_W'(price_i));
  assign credit_o = credit_q;

  // Credit register: clear has priority over add.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      credit_q <= '0;
    end else if (add_i) begin
      credit_q <= sum_o;
    end
  end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: select -> price lookup -> coin collection
// -> dispense with change, or refund on cancel.
// Optional feature macro: VEND_TIMEOUT_EN (auto-refund after TIMEOUT_CYCLES
// idle cycles in COLLECT). Default build has no timeout.
module vend_txn_ctrl
  import vend_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  vend_txn_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   price_addr_q, price_addr_d;
  logic [PRICE_W-1:0]  price_q, price_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic [ADDR_W-1:0]   item_q, item_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_err_q, sel_err_d;

  logic                acc_add, acc_clr, acc_ge;
  logic [CREDIT_W-1:0] credit, acc_sum;
  logic                timeout_hit, cancel_eff;

  vend_credit_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .add_i    (acc_add),
    .clr_i    (acc_clr),
    .coin_i   (bus.coin_val),
    .price_i  (price_q),
    .credit_o (credit),
    .sum_o    (acc_sum),
    .ge_o     (acc_ge)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q;

  // Inactivity timer: zero outside COLLECT (so it starts at 0 on entry), restarts on each accepted coin.
  always_ff @(posedge clk) begin
    if (rst || state_q != COLLECT || acc_add) begin
      timer_q <= '0;
    end else if (timer_q != TMR_W'(TIMEOUT_CYCLES)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == COLLECT) && (timer_q == TMR_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  assign cancel_eff = bus.cancel || timeout_hit;

  // Next-state and registered-output decode; pulses default low every cycle.
  always_comb begin
    state_d        = state_q;
    price_addr_d   = price_addr_q;
    price_d        = price_q;
    change_amt_d   = change_amt_q;
    item_d         = item_q;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    sel_err_d      = 1'b0;
    acc_add        = 1'b0;
    acc_clr        = 1'b0;
    case (state_q)
      IDLE: begin
        coin_reject_d = bus.coin_valid;
        if (bus.sel_valid) begin
          price_addr_d = bus.sel_addr;
          state_d      = LOOKUP;
        end
      end
      LOOKUP: begin
        coin_reject_d = bus.coin_valid;
        price_d       = bus.price_in;
        if (bus.price_in == '0) begin
          sel_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel_eff) begin
          // Cancel beats a simultaneous coin: the coin goes back untouched.
          coin_reject_d = bus.coin_valid;
          if (credit != '0) begin
            change_valid_d = 1'b1;
            change_amt_d   = credit;
            state_d        = REFUND;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.coin_valid) begin
          if (bus.coin_val == '0) begin
            coin_reject_d = 1'b1;
          end else begin
            acc_add = 1'b1;
            if (acc_ge) begin
              // Pulses land in the DISPENSE cycle, computed from the post-coin credit.
              dispense_d = 1'b1;
              item_d     = price_addr_q;
              state_d    = DISPENSE;
              if (acc_sum > CREDIT_W'(price_q)) begin
                change_valid_d = 1'b1;
                change_amt_d   = acc_sum - CREDIT_W'(price_q);
              end
            end
          end
        end
      end
      DISPENSE, REFUND: begin
        coin_reject_d = bus.coin_valid;
        acc_clr       = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      price_addr_q   <= '0;
      price_q        <= '0;
      change_amt_q   <= '0;
      item_q         <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      price_addr_q   <= price_addr_d;
      price_q        <= price_d;
      change_amt_q   <= change_amt_d;
      item_q         <= item_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      sel_err_q      <= sel_err_d;
    end
  end

  assign bus.price_addr    = price_addr_q;
  assign bus.dispense      = dispense_q;
  assign bus.dispense_item = item_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amt    = change_amt_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.sel_err       = sel_err_q;
  assign bus.credit        = credit;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with a behavioural price ROM
// (0->5, 1->10, 2->15, 3->0). Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, i.e. after the edge's update.
module tb_vend_txn_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  vend_txn_ctrl_if bus ();

  vend_txn_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Price ROM model
  always_comb begin
    case (bus.price_addr)
      2'd0:    bus.price_in = 4'd5;
      2'd1:    bus.price_in = 4'd10;
      2'd2:    bus.price_in = 4'd15;
      default: bus.price_in = 4'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [1:0] a);
    bus.sel_valid = 1'b1;
    bus.sel_addr  = a;
    tick();
    bus.sel_valid = 1'b0;
    tick();
  endtask

  task automatic coin(input logic [3:0] v, input logic with_cancel);
    bus.coin_valid = 1'b1;
    bus.coin_val   = v;
    bus.cancel     = with_cancel;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
    bus.cancel     = 1'b0;
  endtask

  initial begin
    bus.sel_valid  = 1'b0;
    bus.sel_addr   = 2'd0;
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
    bus.cancel     = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_credit", bus.credit, 0);
    check("rst_price_addr", bus.price_addr, 0);
    check("rst_change_amt", bus.change_amt, 0);
    check("rst_dispense", bus.dispense, 0);
    rst = 1'b0;
    tick();

    // coin while idle is rejected
    coin(4'd5, 1'b0);
    check("idle_coin_reject", bus.coin_reject, 1);
    check("idle_coin_credit", bus.credit, 0);
    tick();
    $display("txn: idle coin 5 -> rejected");

    // select 1 (price 10), invalid coin 0, then 5 + 5: exact pay
    select(2'd1);
    check("t1_busy", bus.busy, 1);
    coin(4'd0, 1'b0);
    check("t1_zero_coin_reject", bus.coin_reject, 1);
    check("t1_zero_coin_credit", bus.credit, 0);
    coin(4'd5, 1'b0);
    check("t1_credit5", bus.credit, 5);
    check("t1_no_disp_yet", bus.dispense, 0);
    coin(4'd5, 1'b0);
    check("t1_dispense", bus.dispense, 1);
    check("t1_item", bus.dispense_item, 1);
    check("t1_no_change", bus.change_valid, 0);
    tick();
    check("t1_credit_clr", bus.credit, 0);
    check("t1_disp_pulse_end", bus.dispense, 0);
    check("t1_idle", bus.busy, 0);
    $display("txn: select 1, coins 0,5,5 -> dispense item %0d", 1);

    // select 0 (price 5), coin 10: dispense with change 5
    select(2'd0);
    coin(4'd10, 1'b0);
    check("t2_dispense", bus.dispense, 1);
    check("t2_item", bus.dispense_item, 0);
    check("t2_change_valid", bus.change_valid, 1);
    check("t2_change_amt", bus.change_amt, 5);
    tick();
    check("t2_change_pulse_end", bus.change_valid, 0);
    check("t2_credit_clr", bus.credit, 0);
    $display("txn: select 0, coin 10 -> dispense + change 5");

    // select 2 (price 15), coin 5, cancel -> refund 5
    select(2'd2);
    coin(4'd5, 1'b0);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("t3_refund_valid", bus.change_valid, 1);
    check("t3_refund_amt", bus.change_amt, 5);
    check("t3_no_dispense", bus.dispense, 0);
    tick();
    check("t3_credit_clr", bus.credit, 0);
    check("t3_idle", bus.busy, 0);
    $display("txn: select 2, coin 5, cancel -> refund 5");

    // select 3 (price 0): sel_err two edges after sel_valid
    bus.sel_valid = 1'b1;
    bus.sel_addr  = 2'd3;
    tick();
    bus.sel_valid = 1'b0;
    check("t4_no_err_early", bus.sel_err, 0);
    check("t4_busy_lookup", bus.busy, 1);
    tick();
    check("t4_sel_err", bus.sel_err, 1);
    check("t4_busy_after_err", bus.busy, 0);
    tick();
    check("t4_err_pulse_end", bus.sel_err, 0);
    check("t4_still_idle", bus.busy, 0);
    $display("txn: select 3 -> sel_err");

    // cancel with zero credit goes straight to idle, no refund pulse
    select(2'd2);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("t4b_no_refund", bus.change_valid, 0);
    check("t4b_idle", bus.busy, 0);
    $display("txn: select 2, cancel with no credit -> idle");

    // coin 10 together with cancel while credit is 5: cancel wins
    select(2'd2);
    coin(4'd5, 1'b0);
    coin(4'd10, 1'b1);
    check("t5_coin_reject", bus.coin_reject, 1);
    check("t5_refund_valid", bus.change_valid, 1);
    check("t5_refund_amt", bus.change_amt, 5);
    check("t5_credit_not_added", bus.credit, 5);
    tick();
    check("t5_credit_clr", bus.credit, 0);
    $display("txn: credit 5, coin 10 + cancel -> reject, refund 5");

    // reset during COLLECT with credit 10
    select(2'd2);
    coin(4'd10, 1'b0);
    check("t6_credit10", bus.credit, 10);
    rst = 1'b1;
    tick();
    check("t6_busy", bus.busy, 0);
    check("t6_credit", bus.credit, 0);
    check("t6_no_refund", bus.change_valid, 0);
    check("t6_price_addr", bus.price_addr, 0);
    rst = 1'b0;
    tick();
    check("t6_no_refund_after", bus.change_valid, 0);
    $display("txn: reset in COLLECT with credit 10 -> idle, no refund");

`ifdef VEND_TIMEOUT_EN
    begin
      bit found = 0;
      select(2'd1);
      coin(4'd5, 1'b0);
      for (int i = 0; i < 400 && !found; i++) begin
        tick();
        if (bus.change_valid) found = 1;
      end
      check("t7_timeout_refund", found, 1);
      check("t7_timeout_amt", bus.change_amt, 5);
      tick();
      check("t7_idle", bus.busy, 0);
      $display("txn: select 1, coin 5, idle -> timeout refund 5");
    end
`else
    begin
      bit seen = 0;
      select(2'd1);
      coin(4'd5, 1'b0);
      for (int i = 0; i < 300; i++) begin
        tick();
        if (bus.change_valid) seen = 1;
      end
      check("t7_no_timeout", seen, 0);
      check("t7_still_busy", bus.busy, 1);
      check("t7_credit_held", bus.credit, 5);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      check("t7_cancel_amt", bus.change_amt, 5);
      tick();
      $display("txn: select 1, coin 5, wait 300 -> held, cancel refund 5");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
